regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//  Parametrised integer register file for the Instruction Decode stage: two read ports, one write port.
//  Adds three things: a hardware clear sweep after reset, write-to-read bypass, and selectable async/sync read.
//  The clear sweep is needed because the storage is an M10K and cannot be bulk-reset.
//  Sits between the decoder (rs1/rs2/rd fields) and the execute-stage operand muxes.
// PARAMETERS
//  XLEN      32  data width of each register
//  NREGS     32  number of registers; power of two, >= 2
//  SYNC_READ 0   0: combinational read; 1: registered read, 1-cycle latency (M10K-friendly)
//  BYPASS    1   1: a same-cycle write to a register being read is forwarded to the read data
//  ZERO_REG  1   1: register 0 reads as 0 and ignores writes (RISC-V x0)
//  localparam AW = $clog2(NREGS)
// PORTS
//  clk       in   1     clock, rising edge
//  reset     in   1     synchronous, active-high
//  rs1_addr  in   AW    read port 1 address
//  rs2_addr  in   AW    read port 2 address
//  rd_addr   in   AW    write address
//  rd_we     in   1     write enable
//  rd_data   in   XLEN  write data
//  rs1_data  out  XLEN  read port 1 data
//  rs2_data  out  XLEN  read port 2 data
//  init_done out  1     high once the clear sweep completes; the register file is usable
// BEHAVIOUR
//  FSM states: CLEAR, READY. reset=1 -> CLEAR with clr_idx=0 (reset has priority in every state).
//   CLEAR: each cycle write 0 to mem[clr_idx] and increment clr_idx.
//          The cycle that writes clr_idx==NREGS-1 moves to READY. The sweep therefore takes NREGS cycles.
//   READY: normal operation; stays in READY until the next reset.
//  init_done: 0 during reset and CLEAR; registered; goes to 1 on the first READY cycle.
//  Writes: in READY, rd_we=1 writes mem[rd_addr] <= rd_data at the clock edge.
//   Writes to address 0 are dropped when ZERO_REG=1. Any rd_we during CLEAR is dropped silently.
//  Reads (per port, independent; rsN=rs1/rs2):
//   ZERO_REG && rsN_addr==0                                 -> 0
//   else state==CLEAR                                       -> 0
//   else BYPASS && rd_we && rd_addr==rsN_addr (and not x0)  -> rd_data
//   else                                                    -> mem[rsN_addr]
//  SYNC_READ=0: the read result is combinational, in the same cycle as the address.
//  SYNC_READ=1: the read result is registered; data appears the cycle after the address.
//   The bypass compares the write and read addresses of the same cycle, so a write at edge N is visible on the read data registered at edge N.
//   Output registers are cleared to 0 on reset.
//  SYNC_READ=0: outputs follow the read rules; during reset/CLEAR they read 0.
//  Both read ports may address the same register, including the one being written; both return identical data.
//  BYPASS=0: a same-cycle read of the register being written returns the old value (read-before-write).
//  Reset asserted mid-sweep restarts the sweep at clr_idx=0; the partially cleared state is irrelevant.
//  Reset asserted in READY clears init_done on the next edge and reruns the full sweep.
//  No X propagation: every output is defined from the first post-reset edge.
// STRUCTURE
//  Shared package rv_pkg: XLEN_DEF=32, NREGS_DEF=32, rf_state_t enum {RF_CLEAR, RF_READY}.
//  One sub-module: rf_read_port (address, bypass compare, zero-register mux, optional output register),
//   instantiated twice. Storage and the FSM stay in the top level.
//  Storage is inferred RAM carrying the ramstyle attribute M10K; there are no reset terms on the memory array.
// TESTING
//  1. Preload all registers with 0xFFFFFFFF, then reset for 1 cycle -> init_done low for 32 cycles,
//     high on cycle 33; every address then reads 0.
//  2. READY: write 0xDEADBEEF to r5, then read rs1=5 -> 0xDEADBEEF (next cycle when SYNC_READ=1).
//     Write 0x1234 to r0 -> rs2=0 reads 0.
//  3. BYPASS=1: write r7=0xA5A5A5A5 with rs1=rs2=7 in the same cycle -> both ports return 0xA5A5A5A5 at once.
//     BYPASS=0 -> both return the old r7.
//  4. rd_we=1 to r3=0x55 during CLEAR (cycle 10) -> after init_done, r3 reads 0.
//  5. Reset at sweep cycle 20 of 32 -> init_done rises 32 cycles after reset deasserts, not 12.
//  6. Random writes/reads, 10k cycles, NREGS=16, XLEN=64, SYNC_READ=1 -> match the reference model, including latency.

Source files
------------

// File: rtl/regfile_param_pkg.sv
// Shared definitions for the integer register file: default geometry and sweep FSM states.
package rv_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_param_read_port.sv
// One register-file read port: zero-register mux, clear blanking, write bypass and
// an optional output register for M10K-style registered reads.
module rf_read_port #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int SYNC_READ = 0,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            blank,
    input  logic [AW-1:0]   addr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] sel_s;
    logic [XLEN-1:0] data_r;

    // Read-value priority: x0, then blanking while clearing, then bypass, then storage.
    always_comb begin
        sel_s = mem_data;
        if ((ZERO_REG != 0) && (addr == {AW{1'b0}})) begin
            sel_s = {XLEN{1'b0}};
        end else if (blank) begin
            sel_s = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
            sel_s = wr_data;
        end else begin
            sel_s = mem_data;
        end
    end

    // Output register; the write and read of the same cycle meet here, so a bypassed
    // write lands in data_r on the same edge that commits it to storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= {XLEN{1'b0}};
        end else begin
            data_r <= sel_s;
        end
    end

    assign data = (SYNC_READ != 0) ? data_r : sel_s;

endmodule

// File: rtl/regfile_param.sv
// Two-read/one-write integer register file with post-reset clear sweep (storage has no
// reset terms so it can map onto M10K), optional bypass and optional registered read.
module regfile_param
    import rv_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREGS     = NREGS_DEF,
    parameter int SYNC_READ = 0,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG  = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic            rd_we,
    input  logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            init_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    (* ramstyle = "M10K" *) logic [XLEN-1:0] mem_r [NREGS];

    rf_state_t       state_r;
    rf_state_t       state_nxt_s;
    logic [AW-1:0]   clr_idx_r;
    logic [AW-1:0]   clr_idx_nxt_s;
    logic            init_done_r;

    logic            mem_we_s;
    logic [AW-1:0]   mem_waddr_s;
    logic [XLEN-1:0] mem_wdata_s;
    logic            blank_s;

    // Sweep sequencing: one register cleared per cycle, READY after the last one.
    always_comb begin
        state_nxt_s   = state_r;
        clr_idx_nxt_s = clr_idx_r;
        case (state_r)
            RF_CLEAR: begin
                clr_idx_nxt_s = clr_idx_r + ONE_IDX;
                if (clr_idx_r == LAST_IDX) begin
                    state_nxt_s = RF_READY;
                end else begin
                    state_nxt_s = RF_CLEAR;
                end
            end
            RF_READY: begin
                state_nxt_s = RF_READY;
            end
            default: begin
                state_nxt_s   = RF_CLEAR;
                clr_idx_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // FSM state, sweep index and the registered init_done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= RF_CLEAR;
            clr_idx_r   <= {AW{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            clr_idx_r   <= clr_idx_nxt_s;
            init_done_r <= (state_nxt_s == RF_READY);
        end
    end

    // Single write port shared by the sweep and the pipeline; user writes are
    // dropped while clearing and x0 writes are dropped when it is hardwired.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = clr_idx_r;
        mem_wdata_s = {XLEN{1'b0}};
        if (reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == RF_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_idx_r;
            mem_wdata_s = {XLEN{1'b0}};
        end else if (rd_we && !((ZERO_REG != 0) && (rd_addr == {AW{1'b0}}))) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = rd_addr;
            mem_wdata_s = rd_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array: deliberately reset-free.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign blank_s = reset || (state_r == RF_CLEAR);

    rf_read_port #(
        .XLEN      (XLEN),
        .AW        (AW),
        .SYNC_READ (SYNC_READ),
        .BYPASS    (BYPASS),
        .ZERO_REG  (ZERO_REG)
    ) u_rd1 (
        .clk      (clk),
        .reset    (reset),
        .blank    (blank_s),
        .addr     (rs1_addr),
        .wr_en    (rd_we),
        .wr_addr  (rd_addr),
        .wr_data  (rd_data),
        .mem_data (mem_r[rs1_addr]),
        .data     (rs1_data)
    );

    rf_read_port #(
        .XLEN      (XLEN),
        .AW        (AW),
        .SYNC_READ (SYNC_READ),
        .BYPASS    (BYPASS),
        .ZERO_REG  (ZERO_REG)
    ) u_rd2 (
        .clk      (clk),
        .reset    (reset),
        .blank    (blank_s),
        .addr     (rs2_addr),
        .wr_en    (rd_we),
        .wr_addr  (rd_addr),
        .wr_data  (rd_data),
        .mem_data (mem_r[rs2_addr]),
        .data     (rs2_data)
    );

    assign init_done = init_done_r;

endmodule
